// File: rtl/cross_corr_pkg.sv
// Shared widths, FSM state and pipeline token for the cross-correlation sequencer.
package cross_corr_pkg;
  localparam int IMG_WIDTH_G  = 10;
  localparam int TMPL_WIDTH_G = 8;
  localparam int RESULT_WIDTH = 32;
  localparam int IMG_ADDR_W   = IMG_WIDTH_G + TMPL_WIDTH_G;
  localparam int TMPL_ADDR_W  = 2 * TMPL_WIDTH_G;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic                   vld;
    logic                   first;
    logic                   last;
    logic [IMG_WIDTH_G-1:0] x;
  } token_t;

  function automatic logic cfg_valid(input logic [IMG_WIDTH_G-1:0]  img_cols,
                                     input logic [TMPL_WIDTH_G-1:0] tmpl_cols,
                                     input logic [TMPL_WIDTH_G-1:0] tmpl_rows);
    return (img_cols != '0) && (tmpl_cols != '0) && (tmpl_rows != '0) &&
           (IMG_WIDTH_G'(tmpl_cols) <= img_cols);
  endfunction
endpackage

// File: rtl/cross_corr_addr_gen.sv
// Window/row/column walker: produces image and template pixel addresses
// incrementally (no multipliers) plus first/last/final flags for the current pixel.
module cross_corr_addr_gen
  import cross_corr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    adv,
  input  logic [IMG_WIDTH_G-1:0]  img_cols_i,
  input  logic [TMPL_WIDTH_G-1:0] tmpl_cols_i,
  input  logic [TMPL_WIDTH_G-1:0] tmpl_rows_i,
  output logic [IMG_ADDR_W-1:0]   img_addr_o,
  output logic [TMPL_ADDR_W-1:0]  tmpl_addr_o,
  output logic [IMG_WIDTH_G-1:0]  x_o,
  output logic                    first_o,
  output logic                    last_o,
  output logic                    final_o
);
  logic [IMG_WIDTH_G-1:0]  img_cols_q, x_max_q, x_q;
  logic [TMPL_WIDTH_G-1:0] c_max_q, r_max_q, c_q, r_q;
  logic [IMG_ADDR_W-1:0]   row_base_q;
  logic                    c_wrap, r_wrap, x_wrap;

  assign c_wrap      = (c_q == c_max_q);
  assign r_wrap      = (r_q == r_max_q);
  assign x_wrap      = (x_q == x_max_q);
  assign first_o     = (c_q == '0) && (r_q == '0);
  assign last_o      = c_wrap && r_wrap;
  assign final_o     = c_wrap && r_wrap && x_wrap;
  assign x_o         = x_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_cols_q  <= '0;
      x_max_q     <= '0;
      c_max_q     <= '0;
      r_max_q     <= '0;
      c_q         <= '0;
      r_q         <= '0;
      x_q         <= '0;
      row_base_q  <= '0;
      img_addr_o  <= '0;
      tmpl_addr_o <= '0;
    end else if (load) begin
      img_cols_q  <= img_cols_i;
      x_max_q     <= img_cols_i - IMG_WIDTH_G'(tmpl_cols_i);
      c_max_q     <= tmpl_cols_i - TMPL_WIDTH_G'(1);
      r_max_q     <= tmpl_rows_i - TMPL_WIDTH_G'(1);
      c_q         <= '0;
      r_q         <= '0;
      x_q         <= '0;
      row_base_q  <= '0;
      img_addr_o  <= '0;
      tmpl_addr_o <= '0;
    end else if (adv) begin
      if (!c_wrap) begin
        c_q         <= c_q + TMPL_WIDTH_G'(1);
        img_addr_o  <= img_addr_o + IMG_ADDR_W'(1);
        tmpl_addr_o <= tmpl_addr_o + TMPL_ADDR_W'(1);
      end else if (!r_wrap) begin
        // next template row: step the image row base by one full image line
        c_q         <= '0;
        r_q         <= r_q + TMPL_WIDTH_G'(1);
        row_base_q  <= row_base_q + IMG_ADDR_W'(img_cols_q);
        img_addr_o  <= row_base_q + IMG_ADDR_W'(img_cols_q) + IMG_ADDR_W'(x_q);
        tmpl_addr_o <= tmpl_addr_o + TMPL_ADDR_W'(1);
      end else begin
        c_q         <= '0;
        r_q         <= '0;
        x_q         <= x_q + IMG_WIDTH_G'(1);
        row_base_q  <= '0;
        img_addr_o  <= IMG_ADDR_W'(x_q) + IMG_ADDR_W'(1);
        tmpl_addr_o <= '0;
      end
    end
  end
endmodule

// File: rtl/cross_corr_ctrl.sv
// Cross-correlation sequencer: start/done handshake, pixel issue FSM, BRAM-latency
// token pipeline driving MAC clear/enable and response BRAM writes.
module cross_corr_ctrl
  import cross_corr_pkg::*;
#(
  parameter int RD_LAT_G = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    cfg_err_o,
  input  logic                    stall_i,
  input  logic [IMG_WIDTH_G-1:0]  cfg_img_cols_i,
  input  logic [TMPL_WIDTH_G-1:0] cfg_tmpl_cols_i,
  input  logic [TMPL_WIDTH_G-1:0] cfg_tmpl_rows_i,
  output logic                    mem_en_o,
  output logic [IMG_ADDR_W-1:0]   img_addr_o,
  output logic [TMPL_ADDR_W-1:0]  tmpl_addr_o,
  output logic                    mac_en_o,
  output logic                    mac_clr_o,
  output logic                    res_we_o,
  output logic [IMG_WIDTH_G-1:0]  res_addr_o
);
  state_t                  state;
  token_t                  tok_p0;
  token_t                  tok_p [1:RD_LAT_G];
  logic                    cfg_ok, accept, issue, pipe_busy, rej_q;
  logic [IMG_ADDR_W-1:0]   gen_img_addr;
  logic [TMPL_ADDR_W-1:0]  gen_tmpl_addr;
  logic [IMG_WIDTH_G-1:0]  gen_x;
  logic                    gen_first, gen_last, gen_final;

  assign cfg_ok = cfg_valid(cfg_img_cols_i, cfg_tmpl_cols_i, cfg_tmpl_rows_i);
  assign accept = (state == IDLE) && start_i && cfg_ok;
  assign issue  = (state == ISSUE) && !stall_i;

  cross_corr_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .adv        (issue),
    .img_cols_i (cfg_img_cols_i),
    .tmpl_cols_i(cfg_tmpl_cols_i),
    .tmpl_rows_i(cfg_tmpl_rows_i),
    .img_addr_o (gen_img_addr),
    .tmpl_addr_o(gen_tmpl_addr),
    .x_o        (gen_x),
    .first_o    (gen_first),
    .last_o     (gen_last),
    .final_o    (gen_final)
  );

  always_comb begin
    pipe_busy = tok_p0.vld;
    for (int i = 1; i <= RD_LAT_G; i++) pipe_busy = pipe_busy | tok_p[i].vld;
  end

  // Stage p0: issue a pixel read and launch its token
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      rej_q       <= 1'b0;
      cfg_err_o   <= 1'b0;
      mem_en_o    <= 1'b0;
      img_addr_o  <= '0;
      tmpl_addr_o <= '0;
      tok_p0      <= '0;
    end else begin
      done_o   <= rej_q;
      rej_q    <= 1'b0;
      mem_en_o <= 1'b0;
      tok_p0   <= '0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              cfg_err_o <= 1'b0;
              ready_o   <= 1'b0;
              state     <= ISSUE;
            end else begin
              cfg_err_o <= 1'b1;
              rej_q     <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            mem_en_o    <= 1'b1;
            img_addr_o  <= gen_img_addr;
            tmpl_addr_o <= gen_tmpl_addr;
            tok_p0      <= '{vld: 1'b1, first: gen_first, last: gen_last, x: gen_x};
            if (gen_final) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (res_we_o && !pipe_busy) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stages p1..pRD_LAT: token rides alongside the BRAM read; final stage writes the accumulator out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= RD_LAT_G; i++) tok_p[i] <= '0;
      res_we_o   <= 1'b0;
      res_addr_o <= '0;
    end else begin
      tok_p[1] <= tok_p0;
      for (int i = 2; i <= RD_LAT_G; i++) tok_p[i] <= tok_p[i-1];
      res_we_o <= tok_p[RD_LAT_G].vld && tok_p[RD_LAT_G].last;
      if (tok_p[RD_LAT_G].vld && tok_p[RD_LAT_G].last) res_addr_o <= tok_p[RD_LAT_G].x;
    end
  end

  assign mac_en_o  = tok_p[RD_LAT_G].vld;
  assign mac_clr_o = tok_p[RD_LAT_G].vld && tok_p[RD_LAT_G].first;
endmodule

// File: doc/cross_corr_ctrl.md
Name: cross_corr_ctrl

Overview:
Sequencing controller for the cross-correlation MAC datapath. It walks every horizontal template position across one image stripe (tmpl_rows image rows held in image BRAM). It issues pixel-granular read addresses to the image and template BRAMs and drives clear/enable of the datapath accumulator. It writes one 32-bit result per position into the response BRAM. It sits between the AXI-lite register block (config, start/ready) and the BRAM/MAC datapath.

Parameters:
IMG_WIDTH_G, 10, bit width of image column count / response address
TMPL_WIDTH_G, 8, bit width of template row/column counts
RD_LAT_G, 1, BRAM read latency in cycles (1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous assert, active-low
start_i  in  1  start request, sampled only when ready_o=1
ready_o  out  1  high in IDLE
done_o  out  1  one-cycle pulse at end of run or rejected start
cfg_err_o  out  1  sticky: last start had invalid config; cleared by next accepted start
stall_i  in  1  freeze address issue (datapath/BRAM busy)
cfg_img_cols_i  in  IMG_WIDTH_G  image columns
cfg_tmpl_cols_i  in  TMPL_WIDTH_G  template columns
cfg_tmpl_rows_i  in  TMPL_WIDTH_G  template rows
mem_en_o  out  1  read strobe for both BRAMs
img_addr_o  out  IMG_WIDTH_G+TMPL_WIDTH_G  image pixel address = r*img_cols + x + c
tmpl_addr_o  out  2*TMPL_WIDTH_G  template pixel address = r*tmpl_cols + c
mac_en_o  out  1  accumulate the BRAM data now presented
mac_clr_o  out  1  with mac_en_o: load instead of accumulate (first pixel of window)
res_we_o  out  1  response BRAM write strobe (accumulator valid)
res_addr_o  out  IMG_WIDTH_G  response address = window index x

Behaviour:
- Reset (rst=0, async): state IDLE, counters and pipeline cleared. ready_o=1; all other outputs 0, including cfg_err_o. Reset mid-run aborts the run with no done_o.
- Config valid iff all counts nonzero and tmpl_cols <= img_cols. Config is latched on an accepted start; inputs are ignored afterwards.
- IDLE: ready_o=1. On start_i=1:
  - Invalid config: cfg_err_o<=1, done_o pulses next cycle, state stays IDLE, no memory access.
  - Valid config: cfg_err_o<=0, latch config, go ISSUE.
- start_i is ignored outside IDLE.
- ISSUE (ready_o=0):
  - Each cycle with stall_i=0 issues one (x,r,c): mem_en_o=1 with the addresses above.
  - Loop order: c innermost, then r, then x. windows = img_cols-tmpl_cols+1; pixels/window = tmpl_rows*tmpl_cols.
  - Addresses are built from incremental counters (row base += img_cols on r wrap), no multipliers.
  - stall_i=1: mem_en_o=0, counters hold; tokens already in flight still complete.
  - After the last pixel of the last window issues, go DRAIN.
- Pipeline: a token {valid, first, last, x} is delayed RD_LAT_G cycles.
  - mac_en_o = delayed valid; mac_clr_o = delayed valid&first.
  - res_we_o/res_addr_o: last-flag token delayed one further cycle (accumulator register). res_we_o therefore follows the window's last mem_en_o by RD_LAT_G+1 cycles.
- DRAIN: wait until pipeline empty. done_o pulses in the cycle after the final res_we_o, together with return to IDLE (ready_o=1 that cycle).
- Single-pixel window (1x1 template): first and last both set, so mac_clr_o and res_we_o are produced for every pixel.

Decomposition:
- Package cross_corr_pkg:
  - width constants (IMG_WIDTH_G, TMPL_WIDTH_G, RESULT_WIDTH=32)
  - state enum {IDLE, ISSUE, DRAIN}
  - pipeline token struct
- Sub-module cross_corr_addr_gen: c/r/x counters, row base, img/tmpl address registers, first/last/wrap flags. Advances on an enable input.
- Top: FSM, latency shift register, handshakes.

Test Plan:
- Nominal (RD_LAT_G=1, img_cols=4, tmpl 2x2), start accepted at edge k:
  - mem_en_o k+1..k+12; img_addr 0,1,4,5 | 1,2,5,6 | 2,3,6,7; tmpl_addr 0..3 repeating.
  - mac_clr_o at k+2, k+6, k+10.
  - res_we_o at k+6, k+10, k+14 with res_addr_o 0, 1, 2.
  - done_o and ready_o=1 at k+15.
- Stall: same config, stall_i=1 for 3 cycles after the 5th issue -> identical address/res_addr sequence, every later event shifted by 3, done_o at k+18.
- Invalid config: img_cols=4, tmpl_cols=5 -> cfg_err_o=1, done_o at k+1, mem_en_o never asserted, ready_o stays 1. A following valid start clears cfg_err_o.
- Edge sizes: tmpl 1x1, img_cols=3 -> three windows; mac_clr_o and res_we_o on every pixel. tmpl_cols=img_cols=4, rows=1 -> exactly one res_we_o at address 0.
- Reset mid-run: rst=0 during ISSUE -> immediately ready_o=1, all strobes 0, no done_o. A new start then behaves as the nominal case.
- Start while busy: start_i pulsed during ISSUE -> ignored; the sequence is unchanged.
